// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard/forwarding unit: scoreboard slot record,
// safe clog2 width helper and default datapath sizes.
package hazard_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NUM_REGS_DEF = 32;
  // Slot rd field is sized for up to 256 architectural registers.
  localparam int RD_W         = 8;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            reg_write;
    logic            is_load;
  } slot_t;

  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Youngest-producer priority encoder for one decode source operand.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int SELW       = clog2_safe(DEPTH)
) (
  input  slot_t [DEPTH-1:0] i_slots,
  input  logic [RD_W-1:0]   i_rs,
  input  logic              i_rs_used,
  input  logic              i_id_valid,
  output logic              o_hit,
  output logic [SELW-1:0]   o_sel,
  output logic              o_not_ready
);

  logic            w_found;
  logic            w_ready;
  logic [SELW-1:0] w_sel;

  // Scan oldest to youngest so the lowest matching index is the one that sticks.
  always_comb begin
    w_found = 1'b0;
    w_ready = 1'b0;
    w_sel   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i_slots[i].valid && i_slots[i].reg_write && (i_slots[i].rd == i_rs) &&
          (i_rs != '0) && i_rs_used && i_id_valid) begin
        w_found = 1'b1;
        w_sel   = SELW'(i);
        w_ready = !i_slots[i].is_load || (i >= LOAD_STAGE);
      end
    end
  end

  assign o_hit       = w_found && w_ready;
  assign o_sel       = (w_found && w_ready) ? w_sel : '0;
  assign o_not_ready = w_found && !w_ready;

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use hazard detection and rs1/rs2 operand forwarding from a DEPTH-slot scoreboard.
// Optional HAZARD_PERF_EN adds saturating stall/forward event counters.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter  int XLEN       = XLEN_DEF,
  parameter  int NUM_REGS   = NUM_REGS_DEF,
  parameter  int DEPTH      = 3,
  parameter  int LOAD_STAGE = 1,
  localparam int AW         = clog2_safe(NUM_REGS),
  localparam int SELW       = clog2_safe(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [AW-1:0]         id_rs1,
  input  logic [AW-1:0]         id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [AW-1:0]         id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  flush,
  input  logic [DEPTH*XLEN-1:0] stage_data,
  output logic                  stall,
  output logic                  fwd_rs1_hit,
  output logic                  fwd_rs2_hit,
  output logic [SELW-1:0]       fwd_rs1_sel,
  output logic [SELW-1:0]       fwd_rs2_sel,
  output logic [XLEN-1:0]       fwd_rs1_data,
  output logic [XLEN-1:0]       fwd_rs2_data,
  output logic [DEPTH-1:0]      slot_valid
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_fwd_cnt
`endif
);

  logic [DEPTH-1:0]           r_vld;
  logic [DEPTH-1:0][RD_W-1:0] r_rd;
  logic [DEPTH-1:0]           r_rw;
  logic [DEPTH-1:0]           r_ld;
  slot_t [DEPTH-1:0]          w_slots;
  logic [XLEN-1:0]            w_stage [DEPTH];
  logic                       w_accept;
  logic                       w_hit1, w_hit2, w_nr1, w_nr2;
  logic [SELW-1:0]            w_sel1, w_sel2;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_slots[i] = '{valid: r_vld[i], rd: r_rd[i], reg_write: r_rw[i], is_load: r_ld[i]};
      w_stage[i] = stage_data[i*XLEN +: XLEN];
    end
  end

  fwd_select #(.DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SELW(SELW)) u_sel_rs1 (
    .i_slots     (w_slots),
    .i_rs        (RD_W'(id_rs1)),
    .i_rs_used   (id_rs1_used),
    .i_id_valid  (id_valid),
    .o_hit       (w_hit1),
    .o_sel       (w_sel1),
    .o_not_ready (w_nr1)
  );

  fwd_select #(.DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SELW(SELW)) u_sel_rs2 (
    .i_slots     (w_slots),
    .i_rs        (RD_W'(id_rs2)),
    .i_rs_used   (id_rs2_used),
    .i_id_valid  (id_valid),
    .o_hit       (w_hit2),
    .o_sel       (w_sel2),
    .o_not_ready (w_nr2)
  );

  // A flushed decode instruction is dead, so it can never hold the pipe.
  assign stall        = (w_nr1 || w_nr2) && !flush;
  assign w_accept     = id_valid && !stall && !flush;
  assign fwd_rs1_hit  = w_hit1;
  assign fwd_rs2_hit  = w_hit2;
  assign fwd_rs1_sel  = w_sel1;
  assign fwd_rs2_sel  = w_sel2;
  assign fwd_rs1_data = w_hit1 ? w_stage[w_sel1] : '0;
  assign fwd_rs2_data = w_hit2 ? w_stage[w_sel2] : '0;
  assign slot_valid   = r_vld;

  // Slot occupancy: always shifts; a stall only bubbles slot 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_accept;
      for (int i = 1; i < DEPTH; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  // Slot payload is qualified by r_vld and needs no reset.
  always_ff @(posedge clk) begin
    r_rd[0] <= RD_W'(id_rd);
    r_rw[0] <= id_reg_write;
    r_ld[0] <= id_is_load;
    for (int i = 1; i < DEPTH; i++) begin
      r_rd[i] <= r_rd[i-1];
      r_rw[i] <= r_rw[i-1];
      r_ld[i] <= r_ld[i-1];
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_fwd_cnt;
  logic        w_fwd_evt;

  assign w_fwd_evt = (w_hit1 || w_hit2) && !stall && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (stall && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_fwd_evt && (r_fwd_cnt != 32'hFFFF_FFFF)) r_fwd_cnt <= r_fwd_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_fwd_cnt   = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed testbench for hazard_forward_unit (DEPTH=3, LOAD_STAGE=1, XLEN=32).
module tb_hazard_forward_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             id_rs1_used, id_rs2_used;
  logic             id_reg_write, id_is_load;
  logic             flush;
  logic [DEPTH*XLEN-1:0] stage_data;
  logic             stall;
  logic             fwd_rs1_hit, fwd_rs2_hit;
  logic [1:0]       fwd_rs1_sel, fwd_rs2_sel;
  logic [XLEN-1:0]  fwd_rs1_data, fwd_rs2_data;
  logic [DEPTH-1:0] slot_valid;
`ifdef HAZARD_PERF_EN
  logic [31:0]      perf_stall_cnt, perf_fwd_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.XLEN(XLEN), .NUM_REGS(32), .DEPTH(DEPTH), .LOAD_STAGE(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .flush        (flush),
    .stage_data   (stage_data),
    .stall        (stall),
    .fwd_rs1_hit  (fwd_rs1_hit),
    .fwd_rs2_hit  (fwd_rs2_hit),
    .fwd_rs1_sel  (fwd_rs1_sel),
    .fwd_rs2_sel  (fwd_rs2_sel),
    .fwd_rs1_data (fwd_rs1_data),
    .fwd_rs2_data (fwd_rs2_data),
    .slot_valid   (slot_valid)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_fwd_cnt   (perf_fwd_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic v, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                     input logic rw, input logic ld);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_reg_write = rw; id_is_load = ld; flush = 1'b0;
  endtask

  task automatic idle();
    dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic rst_pulse();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    stage_data = '0;
    rst_pulse();
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (fwd_rs1_hit !== 1'b0) begin errors++; $display("FAIL reset_hit1 got %b want 0", fwd_rs1_hit); end
    checks++; if (fwd_rs2_hit !== 1'b0) begin errors++; $display("FAIL reset_hit2 got %b want 0", fwd_rs2_hit); end
    checks++; if (slot_valid !== 3'b000) begin errors++; $display("FAIL reset_slots got %b want 000", slot_valid); end
  endtask

  task automatic test_forward_ex();
    rst_pulse();
    dec(1, 0, 0, 0, 0, 5, 1, 0);
    step();
    stage_data[0*XLEN +: XLEN] = 32'h0000_00AA;
    dec(1, 5, 1, 0, 0, 0, 0, 0);
    #2;
    checks++; if (fwd_rs1_hit !== 1'b1) begin errors++; $display("FAIL ex_hit1 got %b want 1", fwd_rs1_hit); end
    checks++; if (fwd_rs1_sel !== 2'd0) begin errors++; $display("FAIL ex_sel1 got %0d want 0", fwd_rs1_sel); end
    checks++; if (fwd_rs1_data !== 32'hAA) begin errors++; $display("FAIL ex_data1 got %h want 000000aa", fwd_rs1_data); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ex_stall got %b want 0", stall); end
    checks++; if (fwd_rs2_hit !== 1'b0) begin errors++; $display("FAIL ex_hit2 got %b want 0", fwd_rs2_hit); end
    checks++; if (slot_valid !== 3'b001) begin errors++; $display("FAIL ex_slots got %b want 001", slot_valid); end
    step();
  endtask

  task automatic test_load_use();
    rst_pulse();
    dec(1, 0, 0, 0, 0, 6, 1, 1);
    step();
    stage_data[1*XLEN +: XLEN] = 32'hDEAD_BEEF;
    dec(1, 0, 0, 6, 1, 0, 0, 0);
    #2;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b want 1", stall); end
    checks++; if (fwd_rs2_hit !== 1'b0) begin errors++; $display("FAIL lu_hit_during_stall got %b want 0", fwd_rs2_hit); end
    checks++; if (fwd_rs2_data !== 32'h0) begin errors++; $display("FAIL lu_data_during_stall got %h want 0", fwd_rs2_data); end
    step();
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_released got %b want 0", stall); end
    checks++; if (fwd_rs2_hit !== 1'b1) begin errors++; $display("FAIL lu_hit2 got %b want 1", fwd_rs2_hit); end
    checks++; if (fwd_rs2_sel !== 2'd1) begin errors++; $display("FAIL lu_sel2 got %0d want 1", fwd_rs2_sel); end
    checks++; if (fwd_rs2_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lu_data2 got %h want deadbeef", fwd_rs2_data); end
    checks++; if (slot_valid !== 3'b010) begin errors++; $display("FAIL lu_slots got %b want 010", slot_valid); end
    step();
  endtask

  task automatic test_youngest();
    rst_pulse();
    dec(1, 0, 0, 0, 0, 7, 1, 0);
    step();
    idle();
    step();
    dec(1, 0, 0, 0, 0, 7, 1, 0);
    step();
    stage_data[0*XLEN +: XLEN] = 32'h11;
    stage_data[2*XLEN +: XLEN] = 32'h22;
    dec(1, 7, 1, 7, 1, 0, 0, 0);
    #2;
    checks++; if (slot_valid !== 3'b101) begin errors++; $display("FAIL yg_slots got %b want 101", slot_valid); end
    checks++; if (fwd_rs1_sel !== 2'd0) begin errors++; $display("FAIL yg_sel1 got %0d want 0", fwd_rs1_sel); end
    checks++; if (fwd_rs1_data !== 32'h11) begin errors++; $display("FAIL yg_data1 got %h want 00000011", fwd_rs1_data); end
    checks++; if (fwd_rs2_data !== 32'h11) begin errors++; $display("FAIL yg_data2 got %h want 00000011", fwd_rs2_data); end
    idle();
    step();
    step();
    dec(1, 7, 1, 0, 0, 0, 0, 0);
    #2;
    checks++; if (fwd_rs1_hit !== 1'b1) begin errors++; $display("FAIL wb_hit1 got %b want 1", fwd_rs1_hit); end
    checks++; if (fwd_rs1_sel !== 2'd2) begin errors++; $display("FAIL wb_sel1 got %0d want 2", fwd_rs1_sel); end
    checks++; if (fwd_rs1_data !== 32'h22) begin errors++; $display("FAIL wb_data1 got %h want 00000022", fwd_rs1_data); end
    step();
  endtask

  task automatic test_x0();
    rst_pulse();
    dec(1, 0, 0, 0, 0, 0, 1, 1);
    step();
    dec(1, 0, 1, 0, 1, 0, 0, 0);
    #2;
    checks++; if (slot_valid !== 3'b001) begin errors++; $display("FAIL x0_slots got %b want 001", slot_valid); end
    checks++; if (fwd_rs1_hit !== 1'b0) begin errors++; $display("FAIL x0_hit1 got %b want 0", fwd_rs1_hit); end
    checks++; if (fwd_rs2_hit !== 1'b0) begin errors++; $display("FAIL x0_hit2 got %b want 0", fwd_rs2_hit); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_stall got %b want 0", stall); end
    step();
  endtask

  task automatic test_flush();
    rst_pulse();
    dec(1, 0, 0, 0, 0, 6, 1, 1);
    step();
    dec(1, 0, 0, 6, 1, 8, 1, 0);
    flush = 1'b1;
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stall); end
    step();
    idle();
    #1;
    checks++; if (slot_valid !== 3'b010) begin errors++; $display("FAIL flush_slots got %b want 010", slot_valid); end
  endtask

  task automatic test_reset_stall();
    rst_pulse();
    dec(1, 0, 0, 0, 0, 6, 1, 1);
    step();
    dec(1, 0, 0, 6, 1, 0, 0, 0);
    #2;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rs_stall_before got %b want 1", stall); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rs_stall_after got %b want 0", stall); end
    checks++; if (slot_valid !== 3'b000) begin errors++; $display("FAIL rs_slots got %b want 000", slot_valid); end
    idle();
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    rst_pulse();
    #1;
    checks++; if (perf_stall_cnt !== 32'd0) begin errors++; $display("FAIL perf_stall_reset got %0d want 0", perf_stall_cnt); end
    for (int k = 0; k < 4; k++) begin
      dec(1, 0, 0, 0, 0, 6, 1, 1);
      step();
      dec(1, 0, 0, 6, 1, 0, 0, 0);
      step();
      step();
    end
    for (int k = 0; k < 3; k++) begin
      dec(1, 0, 0, 0, 0, 5, 1, 0);
      step();
      dec(1, 5, 1, 0, 0, 0, 0, 0);
      step();
    end
    idle();
    #1;
    checks++; if (perf_stall_cnt !== 32'd4) begin errors++; $display("FAIL perf_stall got %0d want 4", perf_stall_cnt); end
    checks++; if (perf_fwd_cnt !== 32'd7) begin errors++; $display("FAIL perf_fwd got %0d want 7", perf_fwd_cnt); end
  endtask
`endif

  initial begin
    reset = 1'b0;
    stage_data = '0;
    idle();
    test_reset();
    test_forward_ex();
    test_load_use();
    test_youngest();
    test_x0();
    test_flush();
    test_reset_stall();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
